// File: rtl/hpdmc_pkg.sv
// hpdmc_pkg -- shared constants for the HPDMC input-delay controller.
//
// Contents:
//   OP_*     command op-codes carried on cmd_op
//   state_t  controller FSM state encoding (also exported on dbg_state)
//
// Build option: HPDMC_IDELAY_CAL_EN adds the CAL / CALWAIT states used by
// the calibrate command. Without it those states do not exist.
package hpdmc_pkg;

  localparam logic [1:0] OP_RST = 2'b00;  // reset delay taps to 0
  localparam logic [1:0] OP_INC = 2'b01;  // step taps up cmd_count times
  localparam logic [1:0] OP_DEC = 2'b10;  // step taps down cmd_count times
  localparam logic [1:0] OP_CAL = 2'b11;  // calibrate (no-op when disabled)

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_STEP    = 3'd2,
    S_GAP     = 3'd3
`ifdef HPDMC_IDELAY_CAL_EN
    ,
    S_CAL     = 3'd4,
    S_CALWAIT = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/hpdmc_idelay_ctl.sv
// hpdmc_idelay_ctl -- command-driven controller for a 16-bit input delay
// bank (shared RST/CE/INC/CAL controls). It tracks the tap position so the
// memory controller always knows where the delay lines sit.
//
// Parameters:
//   SETTLE   (1..15)  idle cycles after each tap step
//   CAL_WAIT (1..255) cycles spent waiting after the CAL pulse
//
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_op [1:0]             00 reset taps, 01 inc, 10 dec, 11 calibrate
//   cmd_count [7:0]          step count for inc/dec
//   done                     one-cycle pulse on the last cycle of a command
//   sat                      sticky: a step was refused at a tap limit
//   tap [7:0]                tracked tap position
//   dly_rst/ce/inc/cal       controls of the delay bank
//   dbg_state [2:0]          current FSM state (state_t encoding)
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_op/cmd_count are sampled on that edge.
// cmd_ready is high only in IDLE (and not while sys_rst is asserted).
// done is raised on the final cycle of the busy states, so the earliest
// next transfer is the cycle right after done.
//
// Build option: HPDMC_IDELAY_CAL_EN enables the calibrate sequence;
// without it op 11 completes as a no-op and dly_cal is tied low.
module hpdmc_idelay_ctl
  import hpdmc_pkg::*;
#(
  parameter int SETTLE   = 4,
  parameter int CAL_WAIT = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_count,
  output logic       done,
  output logic       sat,
  output logic [7:0] tap,
  output logic       dly_rst,
  output logic       dly_ce,
  output logic       dly_inc,
  output logic       dly_cal,
  output logic [2:0] dbg_state
);

  // Out-of-range parameters stop elaboration.
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("hpdmc_idelay_ctl: SETTLE must be 1..15");
  end
  if (CAL_WAIT < 1 || CAL_WAIT > 255) begin : g_bad_cal_wait
    $error("hpdmc_idelay_ctl: CAL_WAIT must be 1..255");
  end

  // The wait counter is loaded with length-1 and the state exits at zero,
  // so GAP lasts exactly SETTLE cycles.
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
`ifdef HPDMC_IDELAY_CAL_EN
  localparam logic [7:0] CAL_M1 = 8'(CAL_WAIT - 1);
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q;    // GAP / CALWAIT down-counter
  logic [7:0] steps_q;  // tap steps still to issue
  logic       dir_q;    // 1 = increment; 0 for every non-increment command
  logic [7:0] tap_q;
  logic       sat_q;

  logic       accept;
  logic       step_ok;  // STEP issues a real tap move this cycle
  logic       refuse;   // STEP hit a tap limit with steps still pending
  logic       at_limit;

  assign at_limit  = dir_q ? (tap_q == 8'hFF) : (tap_q == 8'h00);
  assign tap       = tap_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    dly_rst   = 1'b0;
    dly_ce    = 1'b0;
    dly_inc   = 1'b0;
    dly_cal   = 1'b0;
    accept    = 1'b0;
    step_ok   = 1'b0;
    refuse    = 1'b0;

    if (sys_rst) begin
      // Pulse the bank reset so the physical taps agree with tap = 0.
      dly_rst = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            accept = 1'b1;
            case (cmd_op)
              OP_RST:  state_d = S_RST;
              OP_INC:  state_d = S_STEP;
              OP_DEC:  state_d = S_STEP;
`ifdef HPDMC_IDELAY_CAL_EN
              default: state_d = S_CAL;
`else
              // Calibrate absent: pass through STEP with zero steps,
              // which finishes with done on the next cycle.
              default: state_d = S_STEP;
`endif
            endcase
          end
        end

        S_RST: begin
          dly_rst = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end

        S_STEP: begin
          dly_inc = dir_q;
          if (steps_q != 8'd0 && !at_limit) begin
            dly_ce  = 1'b1;
            step_ok = 1'b1;
            state_d = S_GAP;
          end else begin
            // Either nothing left to do (count 0 / no-op) or a limit
            // was reached: finish now without touching the bank.
            refuse  = (steps_q != 8'd0);
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end

        S_GAP: begin
          dly_inc = dir_q;
          if (cnt_q == 8'd0) begin
            if (steps_q == 8'd0) begin
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_STEP;
            end
          end
        end

`ifdef HPDMC_IDELAY_CAL_EN
        S_CAL: begin
          dly_cal = 1'b1;
          state_d = S_CALWAIT;
        end

        S_CALWAIT: begin
          if (cnt_q == 8'd0) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      steps_q <= 8'd0;
      dir_q   <= 1'b0;
      tap_q   <= 8'd0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        sat_q   <= 1'b0;
        dir_q   <= (cmd_op == OP_INC);
        steps_q <= (cmd_op == OP_INC || cmd_op == OP_DEC) ? cmd_count : 8'd0;
      end

      if (state_q == S_RST) begin
        tap_q <= 8'd0;
      end

      if (step_ok) begin
        tap_q   <= dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
        steps_q <= steps_q - 8'd1;
        cnt_q   <= SETTLE_M1;
      end

      if (refuse) begin
        sat_q <= 1'b1;
      end

      if (state_q == S_GAP && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end

`ifdef HPDMC_IDELAY_CAL_EN
      if (state_q == S_CAL) begin
        cnt_q <= CAL_M1;
      end
      if (state_q == S_CALWAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_hpdmc_idelay_ctl.sv
// Testbench for hpdmc_idelay_ctl (SETTLE=4, CAL_WAIT=16).
// Expected results per command are pushed to exp_q when the command is
// driven and popped once the DUT signals done.
module tb_hpdmc_idelay_ctl;

  localparam int SETTLE   = 4;
  localparam int CAL_WAIT = 16;
  localparam int W        = 41;  // {lat16, pulses8, rstp4, calp4, tap8, sat1}

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_count;
  logic       done;
  logic       sat;
  logic [7:0] tap;
  logic       dly_rst;
  logic       dly_ce;
  logic       dly_inc;
  logic       dly_cal;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  hpdmc_idelay_ctl #(.SETTLE(SETTLE), .CAL_WAIT(CAL_WAIT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_count(cmd_count),
    .done     (done),
    .sat      (sat),
    .tap      (tap),
    .dly_rst  (dly_rst),
    .dly_ce   (dly_ce),
    .dly_inc  (dly_inc),
    .dly_cal  (dly_cal),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int lat, input int pulses,
                                        input int rstp, input int calp,
                                        input int t, input int s);
    return {16'(lat), 8'(pulses), 4'(rstp), 4'(calp), 8'(t), 1'(s)};
  endfunction

  // Drive one command at a negedge, follow it to done, then score it.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] n,
                         input logic [W-1:0] e);
    int w, lat, pulses, rstp, calp, last_ce, excl;
    logic [W-1:0] x;
    exp_q.push_back(e);
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = n;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 8'd0;
    check("ready_low_after_accept", int'(cmd_ready), 0);
    lat = 1; pulses = 0; rstp = 0; calp = 0; last_ce = -1;
    forever begin
      excl = int'(dly_ce) + int'(dly_rst) + int'(dly_cal);
      if (excl > 1) check("ctrl_exclusive", excl, 1);
      if (dly_ce) begin
        pulses++;
        check("inc_matches_op", int'(dly_inc), int'(op == 2'b01));
        if (last_ce >= 0) check("ce_spacing", lat - last_ce, SETTLE + 1);
        last_ce = lat;
      end
      if (dly_rst) rstp++;
      if (dly_cal) calp++;
      if (done) begin
        check("ready_low_on_done", int'(cmd_ready), 0);
        break;
      end
      if (lat >= 5000) begin
        check("done_timeout", 0, 1);
        break;
      end
      @(negedge sys_clk);
      lat++;
    end
    @(negedge sys_clk);
    check("ready_after_done", int'(cmd_ready), 1);
    check("done_single_pulse", int'(done), 0);
    x = exp_q.pop_front();
    check("latency", lat, int'(x[40:25]));
    check("ce_pulses", pulses, int'(x[24:17]));
    check("rst_pulses", rstp, int'(x[16:13]));
    check("cal_pulses", calp, int'(x[12:9]));
    check("tap", int'(tap), int'(x[8:1]));
    check("sat", int'(sat), int'(x[0]));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  count;
    logic [15:0] lat;
    logic [7:0]  pulses;
    logic [7:0]  tap;
    logic        sat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int done_seen;
    logic [W-1:0] e;

    // Step period is 1 STEP + SETTLE GAP cycles = 5.
    vecs[0]  = '{2'b01, 8'd3,   16'd15,   8'd3,   8'd3,   1'b0};
    vecs[1]  = '{2'b10, 8'd5,   16'd16,   8'd3,   8'd0,   1'b1};
    vecs[2]  = '{2'b01, 8'd0,   16'd1,    8'd0,   8'd0,   1'b0};
    vecs[3]  = '{2'b10, 8'd2,   16'd1,    8'd0,   8'd0,   1'b1};
    vecs[4]  = '{2'b01, 8'd7,   16'd35,   8'd7,   8'd7,   1'b0};
    vecs[5]  = '{2'b00, 8'd9,   16'd1,    8'd0,   8'd0,   1'b0};
    vecs[6]  = '{2'b01, 8'd254, 16'd1270, 8'd254, 8'd254, 1'b0};
    vecs[7]  = '{2'b01, 8'd4,   16'd6,    8'd1,   8'd255, 1'b1};
    vecs[8]  = '{2'b01, 8'd1,   16'd1,    8'd0,   8'd255, 1'b1};
    vecs[9]  = '{2'b10, 8'd2,   16'd10,   8'd2,   8'd253, 1'b0};
    vecs[10] = '{2'b00, 8'd0,   16'd1,    8'd0,   8'd0,   1'b0};

    // ---------------- reset ----------------
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = 8'd0;
    repeat (3) @(negedge sys_clk);
    check("rst_dly_rst", int'(dly_rst), 1);
    check("rst_dly_ce", int'(dly_ce), 0);
    check("rst_dly_inc", int'(dly_inc), 0);
    check("rst_dly_cal", int'(dly_cal), 0);
    check("rst_done", int'(done), 0);
    check("rst_tap", int'(tap), 0);
    check("rst_sat", int'(sat), 0);
    sys_rst = 1'b0;
    #1;
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_dly_rst", int'(dly_rst), 0);
    @(negedge sys_clk);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 11; i++) begin
      e = pack(int'(vecs[i].lat), int'(vecs[i].pulses),
               (vecs[i].op == 2'b00) ? 1 : 0, 0,
               int'(vecs[i].tap), int'(vecs[i].sat));
      run_cmd(vecs[i].op, vecs[i].count, e);
    end

    // ---------------- calibrate leaves tap alone ----------------
    run_cmd(2'b01, 8'd5, pack(25, 5, 0, 0, 5, 0));
`ifdef HPDMC_IDELAY_CAL_EN
    run_cmd(2'b11, 8'd3, pack(CAL_WAIT + 1, 0, 0, 1, 5, 0));
`else
    run_cmd(2'b11, 8'd3, pack(1, 0, 0, 0, 5, 0));
`endif

    // ---------------- back-to-back count-0 commands ----------------
    run_cmd(2'b00, 8'd0, pack(1, 0, 1, 0, 0, 0));
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 8'd0;
    @(negedge sys_clk);
    check("b2b_done1", int'(done), 1);
    check("b2b_ready1", int'(cmd_ready), 0);
    check("b2b_no_ce1", int'(dly_ce), 0);
    @(negedge sys_clk);
    check("b2b_ready2", int'(cmd_ready), 1);
    check("b2b_no_done_gap", int'(done), 0);
    @(negedge sys_clk);
    check("b2b_done2", int'(done), 1);
    check("b2b_no_ce2", int'(dly_ce), 0);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    check("b2b_idle_ready", int'(cmd_ready), 1);
    check("b2b_done_end", int'(done), 0);

    // ---------------- reset during GAP ----------------
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 8'd10;
    @(negedge sys_clk);          // STEP cycle
    cmd_valid = 1'b0;
    check("abort_step_ce", int'(dly_ce), 1);
    @(negedge sys_clk);          // first GAP cycle
    @(negedge sys_clk);          // second GAP cycle
    check("abort_mid_tap", int'(tap), 1);
    check("abort_mid_ready", int'(cmd_ready), 0);
    sys_rst = 1'b1;
    #1;
    check("abort_dly_rst", int'(dly_rst), 1);
    check("abort_no_done", int'(done), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("abort_ready", int'(cmd_ready), 1);
    check("abort_tap", int'(tap), 0);
    check("abort_sat", int'(sat), 0);
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      if (done || dly_ce) done_seen++;
    end
    check("abort_stays_idle", done_seen, 0);

    // Table of leftovers must be empty.
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case something wedges the sequence itself.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hpdmc_idelay_ctl.md
HPDMC_IDELAY_CTL -- requirements
Module: hpdmc_idelay_ctl

Interface
REQ-001 Parameter SETTLE, default 4: idle cycles after each tap step before the next step; legal range 1..15.
REQ-002 Parameter CAL_WAIT, default 16: cycles held in calibration wait after the CAL pulse; legal range 1..255.
REQ-003 sys_clk  in  1  sole clock; all logic rises on it.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high when the controller accepts a command.
REQ-007 cmd_op  in  2  command code: 00 reset taps, 01 increment, 10 decrement, 11 calibrate.
REQ-008 cmd_count  in  8  number of tap steps for 01/10; ignored otherwise.
REQ-009 done  out  1  one-cycle pulse when a command completes.
REQ-010 sat  out  1  sticky; set when a step is refused at a tap limit; cleared on next accepted command.
REQ-011 tap  out  8  tracked delay tap position.
REQ-012 dly_rst, dly_ce, dly_inc, dly_cal  out  1 each  drive RST, CE, INC and CAL of the 16-bit input delay bank.

Function
REQ-013 Handshake SHALL be: command accepted on the cycle where cmd_valid and cmd_ready are both high; cmd_op and cmd_count are sampled on that cycle.
REQ-014 cmd_ready SHALL be high only in IDLE, and low on the cycle after acceptance.
REQ-015 FSM states SHALL be IDLE, RST, STEP, GAP, CAL and CALWAIT.
REQ-016 op 00 SHALL go IDLE->RST, drive dly_rst for exactly one cycle, set tap to 0, then return to IDLE with done.
REQ-017 op 01/10 SHALL alternate STEP and GAP states.
REQ-018 In STEP, dly_ce SHALL pulse for one cycle, with dly_inc=1 for increment or 0 for decrement, and tap SHALL change by ±1 on that cycle.
REQ-019 GAP SHALL last SETTLE cycles.
REQ-020 After cmd_count steps, the last GAP SHALL exit to IDLE with done.
REQ-021 cmd_count=0 SHALL produce no dly_ce pulse; done SHALL follow one cycle after acceptance.
REQ-022 Saturation: an increment at tap=255 or a decrement at tap=0 SHALL NOT pulse dly_ce, SHALL set sat and SHALL end the command immediately with done; tap SHALL never wrap.
REQ-023 dly_inc SHALL hold its value from STEP through GAP.
REQ-024 dly_inc SHALL be 0 in all other states.
REQ-025 op 11 SHALL drive dly_cal for one cycle in CAL, then spend CAL_WAIT cycles in CALWAIT, then return to IDLE with done.
REQ-026 op 11 SHALL leave tap unchanged.
REQ-027 dly_ce, dly_rst and dly_cal SHALL be mutually exclusive in every cycle.
REQ-028 done SHALL never coincide with cmd_ready-qualified acceptance of the next command.
REQ-029 The earliest new acceptance SHALL be the cycle after done.

Reset
REQ-030 sys_rst SHALL force IDLE.
REQ-031 sys_rst SHALL set tap=0, sat=0, done=0, and dly_ce=dly_inc=dly_cal=0.
REQ-032 sys_rst SHALL set dly_rst=1 on the reset cycle, so that the delay taps match tap=0.
REQ-033 Reset asserted mid-command SHALL abort it with no done pulse.
REQ-034 cmd_ready SHALL be 1 on the first cycle after sys_rst deasserts.

Configuration
REQ-035 Macro HPDMC_IDELAY_CAL_EN defined: op 11 SHALL behave per REQ-025 and REQ-026.
REQ-036 Macro HPDMC_IDELAY_CAL_EN undefined: the CAL and CALWAIT states SHALL be absent.
REQ-037 Macro HPDMC_IDELAY_CAL_EN undefined: dly_cal SHALL be tied 0.
REQ-038 Macro HPDMC_IDELAY_CAL_EN undefined: op 11 SHALL complete as a no-op with done one cycle after acceptance.

Structure
REQ-039 Op-code constants and the FSM state encoding SHALL live in a shared package, hpdmc_pkg.
REQ-040 The block SHALL be a single module with no sub-modules.
REQ-041 The GAP/CALWAIT counter SHALL be an 8-bit down-counter inside the FSM.

Verification
REQ-042 Reset, then op 01 with count 3, SETTLE=4: three dly_ce pulses 5 cycles apart with dly_inc=1, then tap=3, one done pulse, sat=0.
REQ-043 From tap=3, op 10 with count 5: three dly_ce pulses, then tap=0, sat=1, done immediately after the third gap.
REQ-044 Force tap to 254, then op 01 with count 4: one pulse, then tap=255, sat=1, no wrap to 0.
REQ-045 op 11 with CAL_WAIT=16 and macro defined: one dly_cal pulse, done 17 cycles later, tap unchanged; with macro undefined: no dly_cal, done one cycle after acceptance.
REQ-046 Assert sys_rst during GAP of an op 01 with count 10: no done; dly_rst pulses; tap=0; cmd_ready high the cycle after reset.
REQ-047 op 01 with count 0, plus back-to-back cmd_valid held high: done one cycle after acceptance, with no dly_ce; the second command accepted the cycle after done.
